// File: rtl/cmd_pkg.sv
// Shared types and response codes for the command scheduler.
package cmd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    EXEC,
    RESP
  } state_t;

  typedef enum logic {
    SRC_UART,
    SRC_TOUR
  } src_t;

  typedef struct packed {
    src_t        src;
    logic [15:0] cmd;
  } hold_t;

  localparam logic [7:0] RESP_ACK   = 8'hA5;
  localparam logic [7:0] RESP_NAK   = 8'h5A;
  localparam logic [7:0] RESP_ABORT = 8'hEE;

endpackage

// File: rtl/cmd_fifo.sv
// 16-bit command queue; power-of-two depth so pointers wrap
// naturally. A pop frees a slot for a push in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [15:0]            din,
  input  logic                   pop,
  output logic [15:0]            dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cmd_sched.sv
// Arbitrates tour and queued UART commands onto a single
// processor port with a watchdog on command execution.
module cmd_sched
  import cmd_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [23:0] TIMEOUT = 24'd10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  input  logic [15:0] tour_cmd,
  input  logic        tour_cmd_rdy,
  input  logic        tour_active,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        tour_clr,
  output logic        tour_resp,
  output logic [7:0]  resp,
  output logic        resp_vld,
  output logic        q_full,
  output logic        ovfl,
  output logic        busy
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  hold_t         hold;
  logic [23:0]   wdog;
  logic [15:0]   q_head;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic          accept;
  logic          pop;
  logic          push_ok;
  logic          grant_tour;
  logic          grant_uart;
  logic          done;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_rdy_UART),
    .din   (cmd_UART),
    .pop   (pop),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  assign grant_tour = (state == IDLE)
                    && tour_active
                    && tour_cmd_rdy;
  assign grant_uart = (state == IDLE)
                    && !tour_active
                    && !q_empty;

  assign accept   = (state == PRESENT) && clr_cmd_rdy;
  assign pop      = accept && (hold.src == SRC_UART);
  assign tour_clr = accept && (hold.src == SRC_TOUR);
  assign push_ok  = cmd_rdy_UART && (!q_full || pop);
  assign done     = send_resp
                 || (wdog == TIMEOUT - 24'd1);

  assign cmd  = hold.cmd;
  assign busy = state != IDLE;

  // Sticky until the queue drains through a dequeue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl <= 1'b0;
    end else if (cmd_rdy_UART && !push_ok) begin
      ovfl <= 1'b1;
    end else if (pop && !push_ok
                 && q_count == CW'(1)) begin
      ovfl <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      wdog      <= '0;
      cmd_rdy   <= 1'b0;
      tour_resp <= 1'b0;
      resp      <= '0;
      resp_vld  <= 1'b0;
    end else begin
      tour_resp <= 1'b0;
      resp_vld  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_tour) begin
            hold    <= '{src: SRC_TOUR, cmd: tour_cmd};
            cmd_rdy <= 1'b1;
            state   <= PRESENT;
          end else if (grant_uart) begin
            hold    <= '{src: SRC_UART, cmd: q_head};
            cmd_rdy <= 1'b1;
            state   <= PRESENT;
          end
        end
        PRESENT: begin
          if (clr_cmd_rdy) begin
            cmd_rdy <= 1'b0;
            wdog    <= '0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (done) begin
            state <= RESP;
            if (hold.src == SRC_UART) begin
              resp_vld <= 1'b1;
              resp     <= send_resp ? RESP_ACK
                                    : RESP_ABORT;
            end else begin
              tour_resp <= 1'b1;
            end
          end else begin
            wdog <= wdog + 24'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sched.sv
// Scenario bench for cmd_sched with a queue-level reference
// model driving a randomized UART/processor exchange.
module tb_cmd_sched;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd_UART = '0;
  logic        cmd_rdy_UART = 1'b0;
  logic [15:0] tour_cmd = '0;
  logic        tour_cmd_rdy = 1'b0;
  logic        tour_active = 1'b0;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        tour_clr;
  logic        tour_resp;
  logic [7:0]  resp;
  logic        resp_vld;
  logic        q_full;
  logic        ovfl;
  logic        busy;

  int checks = 0;
  int errors = 0;

  cmd_sched #(
    .DEPTH   (DEPTH),
    .TIMEOUT (24'd16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_UART     (cmd_UART),
    .cmd_rdy_UART (cmd_rdy_UART),
    .tour_cmd     (tour_cmd),
    .tour_cmd_rdy (tour_cmd_rdy),
    .tour_active  (tour_active),
    .clr_cmd_rdy  (clr_cmd_rdy),
    .send_resp    (send_resp),
    .cmd          (cmd),
    .cmd_rdy      (cmd_rdy),
    .tour_clr     (tour_clr),
    .tour_resp    (tour_resp),
    .resp         (resp),
    .resp_vld     (resp_vld),
    .q_full       (q_full),
    .ovfl         (ovfl),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (cmd_rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd, resp} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0",
               {cmd, resp});
    end
    checks++;
    if ({cmd_rdy, tour_clr, tour_resp, resp_vld,
         q_full, ovfl, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0",
               {cmd_rdy, tour_clr, tour_resp, resp_vld,
                q_full, ovfl, busy});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cmd_UART = 16'h2001;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    cmd_rdy_UART = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_c1 got=%b exp=0", cmd_rdy);
    end
    @(negedge clk);
    checks++;
    if (cmd_rdy !== 1'b1 || cmd !== 16'h2001
        || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_c2 got=%b/%h/%b exp=1/2001/1",
               cmd_rdy, cmd, busy);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    checks++;
    if (cmd_rdy !== 1'b0 || cmd !== 16'h2001) begin
      errors++;
      $display("FAIL basic_exec got=%b/%h exp=0/2001",
               cmd_rdy, cmd);
    end
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    checks++;
    if (resp_vld !== 1'b1 || resp !== 8'hA5) begin
      errors++;
      $display("FAIL basic_resp got=%b/%h exp=1/a5",
               resp_vld, resp);
    end
    @(negedge clk);
    checks++;
    if (resp_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got=%b/%b exp=0/0",
               resp_vld, busy);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    int seen;
    tour_active = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmd_UART = 16'h1000 + 16'(i);
      cmd_rdy_UART = 1'b1;
      @(negedge clk);
    end
    cmd_rdy_UART = 1'b0;
    @(negedge clk);
    checks++;
    if (q_full !== 1'b1 || ovfl !== 1'b1
        || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL ovfl_flags got=%b/%b/%b exp=1/1/0",
               q_full, ovfl, cmd_rdy);
    end
    tour_active = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_rdy(ok);
      checks++;
      if (!ok || cmd !== 16'h1000 + 16'(i)) begin
        errors++;
        $display("FAIL ovfl_order%0d got=%b/%h exp=1/%h",
                 i, ok, cmd, 16'h1000 + 16'(i));
      end
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      checks++;
      if (ovfl !== (i < 3) || q_full !== 1'b0) begin
        errors++;
        $display("FAIL ovfl_sticky%0d got=%b/%b exp=%b/0",
                 i, ovfl, q_full, i < 3);
      end
      send_resp = 1'b1;
      @(negedge clk);
      send_resp = 1'b0;
      checks++;
      if (resp_vld !== 1'b1 || resp !== 8'hA5) begin
        errors++;
        $display("FAIL ovfl_resp%0d got=%b/%h exp=1/a5",
                 i, resp_vld, resp);
      end
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (cmd_rdy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL ovfl_fifth got=%0d exp=0", seen);
    end
  endtask

  task automatic test_tour();
    bit ok;
    tour_active = 1'b1;
    cmd_UART = 16'h0777;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    cmd_rdy_UART = 1'b0;
    tour_cmd = 16'h33F1;
    tour_cmd_rdy = 1'b1;
    wait_rdy(ok);
    checks++;
    if (!ok || cmd !== 16'h33F1) begin
      errors++;
      $display("FAIL tour_grant got=%b/%h exp=1/33f1",
               ok, cmd);
    end
    clr_cmd_rdy = 1'b1;
    #1;
    checks++;
    if (tour_clr !== 1'b1) begin
      errors++;
      $display("FAIL tour_clr got=%b exp=1", tour_clr);
    end
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    tour_cmd_rdy = 1'b0;
    tour_active = 1'b0;
    #1;
    checks++;
    if (tour_clr !== 1'b0 || cmd_rdy !== 1'b0) begin
      errors++;
      $display("FAIL tour_pulse got=%b/%b exp=0/0",
               tour_clr, cmd_rdy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cmd_rdy !== 1'b0
        || cmd !== 16'h33F1) begin
      errors++;
      $display("FAIL tour_hold got=%b/%b/%h exp=1/0/33f1",
               busy, cmd_rdy, cmd);
    end
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    checks++;
    if (tour_resp !== 1'b1 || resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL tour_resp got=%b/%b exp=1/0",
               tour_resp, resp_vld);
    end
    wait_rdy(ok);
    checks++;
    if (!ok || cmd !== 16'h0777) begin
      errors++;
      $display("FAIL tour_uart got=%b/%h exp=1/0777",
               ok, cmd);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    checks++;
    if (resp_vld !== 1'b1 || resp !== 8'hA5) begin
      errors++;
      $display("FAIL tour_uresp got=%b/%h exp=1/a5",
               resp_vld, resp);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    cmd_UART = 16'h4242;
    cmd_rdy_UART = 1'b1;
    @(negedge clk);
    cmd_rdy_UART = 1'b0;
    wait_rdy(ok);
    clr_cmd_rdy = 1'b1;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      if (resp_vld) break;
      n++;
    end
    checks++;
    if (!ok || n !== 16 || resp !== 8'hEE) begin
      errors++;
      $display("FAIL timeout got=%0d/%h exp=16/ee",
               n, resp);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp_vld !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle got=%b/%b exp=0/0",
               busy, resp_vld);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    tour_active = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cmd_UART = 16'h5001 + 16'(i);
      cmd_rdy_UART = 1'b1;
      @(negedge clk);
    end
    cmd_rdy_UART = 1'b0;
    tour_cmd = 16'h6001;
    tour_cmd_rdy = 1'b1;
    wait_rdy(ok);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    tour_cmd_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_exec got=%b/%b exp=1/1", ok, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd, resp, cmd_rdy, tour_clr, tour_resp,
         resp_vld, q_full, ovfl, busy} !== 31'h0) begin
      errors++;
      $display("FAIL rmid_reset got=%h exp=0",
               {cmd, resp, cmd_rdy, tour_clr, tour_resp,
                resp_vld, q_full, ovfl, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    tour_active = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (cmd_rdy || resp_vld || tour_resp || busy) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rmid_quiet got=%0d exp=0", bad);
    end
  endtask

  task automatic test_random();
    logic [15:0] mq[$];
    logic [15:0] exp_c;
    bit mov = 1'b0;
    bit presented = 1'b0;
    bit in_exec = 1'b0;
    bit expect_resp = 1'b0;
    bit was_exec, pop, strobe, pushed;
    int wait_n = 0;
    tour_active = 1'b0;
    tour_cmd_rdy = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      checks++;
      if (q_full !== (mq.size() == DEPTH)
          || ovfl !== mov) begin
        errors++;
        $display("FAIL rnd_flags@%0d got=%b/%b exp=%b/%b",
                 i, q_full, ovfl,
                 mq.size() == DEPTH, mov);
      end
      checks++;
      if (expect_resp) begin
        expect_resp = 1'b0;
        if (resp_vld !== 1'b1 || resp !== 8'hA5) begin
          errors++;
          $display("FAIL rnd_resp@%0d got=%b/%h exp=1/a5",
                   i, resp_vld, resp);
        end
      end else if (resp_vld !== 1'b0) begin
        errors++;
        $display("FAIL rnd_spur@%0d got=%b exp=0",
                 i, resp_vld);
      end
      if (cmd_rdy && !presented) begin
        presented = 1'b1;
        exp_c = (mq.size() > 0) ? mq[0] : 16'hxxxx;
        checks++;
        if (mq.size() == 0 || cmd !== exp_c) begin
          errors++;
          $display("FAIL rnd_cmd@%0d got=%h exp=%h",
                   i, cmd, exp_c);
        end
      end
      if (i >= 500 && mq.size() == 0 && !presented
          && !in_exec && !busy) break;
      was_exec = in_exec;
      send_resp = 1'b0;
      clr_cmd_rdy = 1'b0;
      if (was_exec) begin
        if (wait_n == 0) begin
          send_resp = 1'b1;
          in_exec = 1'b0;
          expect_resp = 1'b1;
        end else begin
          wait_n--;
        end
      end else if ($urandom_range(7) == 0) begin
        send_resp = 1'b1;
      end
      pop = 1'b0;
      if (presented && $urandom_range(1) == 1) begin
        clr_cmd_rdy = 1'b1;
        pop = 1'b1;
        presented = 1'b0;
        in_exec = 1'b1;
        wait_n = $urandom_range(7);
      end else if (!cmd_rdy && $urandom_range(7) == 0) begin
        clr_cmd_rdy = 1'b1;
      end
      strobe = (i < 500) && ($urandom_range(2) == 0);
      cmd_rdy_UART = strobe;
      cmd_UART = 16'($urandom);
      pushed = strobe && (mq.size() < DEPTH || pop);
      if (pop) void'(mq.pop_front());
      if (pushed) mq.push_back(cmd_UART);
      else if (strobe) mov = 1'b1;
      if (pop && mq.size() == 0) mov = 1'b0;
    end
    cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0;
    send_resp = 1'b0;
    checks++;
    if (mq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rnd_drain got=%0d/%b exp=0/0",
               mq.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_tour();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
